// File: rtl/stq_fwd_drain_if.sv
// Store-queue port bundle: dispatch, execute, load lookup, retire/flush and Dcache drain.
// master = core/Dcache side driving requests, slave = the store queue.
interface stq_fwd_drain_if #(
    parameter int unsigned STQ_IDX = 3,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned PR_W    = 7
);
    localparam int unsigned TAG_W = STQ_IDX + 1;

    logic              disp_st0;
    logic              disp_st1;
    logic [TAG_W-1:0]  disp_idx0;
    logic [TAG_W-1:0]  disp_idx1;
    logic [TAG_W-1:0]  stq_free;

    logic              exe_valid;
    logic [TAG_W-1:0]  exe_idx;
    logic [ADDR_W-1:0] exe_addr;
    logic [DATA_W-1:0] exe_data;

    logic              ld_valid;
    logic [TAG_W-1:0]  ld_age;
    logic [ADDR_W-1:0] ld_addr;
    logic [PR_W-1:0]   ld_pr;
    logic              ld_rsp_valid;
    logic              ld_rsp_hit;
    logic              ld_rsp_stall;
    logic [DATA_W-1:0] ld_rsp_data;
    logic [PR_W-1:0]   ld_rsp_pr;

    logic [1:0]        retire_st;
    logic              flush;

    logic              dc_wr_valid;
    logic [ADDR_W-1:0] dc_wr_addr;
    logic [DATA_W-1:0] dc_wr_data;
    logic              dc_wr_ack;

    modport master (
        output disp_st0, disp_st1, exe_valid, exe_idx, exe_addr, exe_data,
               ld_valid, ld_age, ld_addr, ld_pr, retire_st, flush, dc_wr_ack,
        input  disp_idx0, disp_idx1, stq_free, ld_rsp_valid, ld_rsp_hit, ld_rsp_stall,
               ld_rsp_data, ld_rsp_pr, dc_wr_valid, dc_wr_addr, dc_wr_data
    );

    modport slave (
        input  disp_st0, disp_st1, exe_valid, exe_idx, exe_addr, exe_data,
               ld_valid, ld_age, ld_addr, ld_pr, retire_st, flush, dc_wr_ack,
        output disp_idx0, disp_idx1, stq_free, ld_rsp_valid, ld_rsp_hit, ld_rsp_stall,
               ld_rsp_data, ld_rsp_pr, dc_wr_valid, dc_wr_addr, dc_wr_data
    );
endinterface

// File: rtl/stq_fwd_drain.sv
// Store queue: allocate at dispatch, fill at execute, forward to younger loads,
// commit at retire, squash on flush and drain committed stores to the Dcache.
module stq_fwd_drain #(
    parameter int unsigned STQ_DEPTH = 8,
    parameter int unsigned STQ_IDX   = 3,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned PR_W      = 7
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    stq_fwd_drain_if.slave io_stq
);
    localparam int unsigned TAG_W  = STQ_IDX + 1;
    localparam int unsigned CMP_LO = 3;
    localparam logic [TAG_W-1:0] DEPTH_TAG = TAG_W'(STQ_DEPTH);

    typedef enum logic {S_IDLE, S_REQ} drain_state_t;

    logic [TAG_W-1:0]     r_head;
    logic [TAG_W-1:0]     r_commit;
    logic [TAG_W-1:0]     r_tail;
    logic [TAG_W-1:0]     r_free;
    logic [STQ_DEPTH-1:0] r_valid;
    logic [STQ_DEPTH-1:0] r_rdy;
    logic [ADDR_W-1:0]    r_addr [STQ_DEPTH];
    logic [DATA_W-1:0]    r_data [STQ_DEPTH];

    drain_state_t         r_state;
    logic                 r_dc_valid;
    logic [ADDR_W-1:0]    r_dc_addr;
    logic [DATA_W-1:0]    r_dc_data;

    logic                 r_rsp_valid;
    logic                 r_rsp_hit;
    logic                 r_rsp_stall;
    logic [DATA_W-1:0]    r_rsp_data;
    logic [PR_W-1:0]      r_rsp_pr;

    logic                 w_alloc0;
    logic                 w_alloc1;
    logic [TAG_W-1:0]     w_tag1;
    logic [TAG_W-1:0]     w_inflight;
    logic [TAG_W-1:0]     w_retire;
    logic [TAG_W-1:0]     w_commit_nxt;
    logic [TAG_W-1:0]     w_tail_nxt;
    logic [TAG_W-1:0]     w_head_nxt;
    logic [TAG_W-1:0]     w_flush_cnt;
    logic                 w_drain_ack;
    logic                 w_exe_ok;
    logic [STQ_DEPTH-1:0] w_squash;
    logic [TAG_W-1:0]     w_scan_cnt;
    logic                 w_done;
    logic                 w_hit;
    logic                 w_stall;
    logic [DATA_W-1:0]    w_fdata;

    // Pointer bookkeeping: allocation gated by free space, retire clamped to tail, flush rewinds tail
    always_comb begin
        w_alloc0     = io_stq.disp_st0 && (r_free != '0) && !io_stq.flush;
        w_alloc1     = io_stq.disp_st1 && (r_free > TAG_W'(w_alloc0)) && !io_stq.flush;
        w_tag1       = r_tail + TAG_W'(w_alloc0);
        w_inflight   = r_tail - r_commit;
        w_retire     = (TAG_W'(io_stq.retire_st) > w_inflight) ? w_inflight
                                                                : TAG_W'(io_stq.retire_st);
        w_commit_nxt = r_commit + w_retire;
        w_tail_nxt   = io_stq.flush ? w_commit_nxt
                                    : r_tail + TAG_W'(w_alloc0) + TAG_W'(w_alloc1);
        w_drain_ack  = (r_state == S_REQ) && io_stq.dc_wr_ack;
        w_head_nxt   = r_head + TAG_W'(w_drain_ack);
        w_exe_ok     = io_stq.exe_valid && r_valid[STQ_IDX'(io_stq.exe_idx)];
        w_flush_cnt  = r_tail - w_commit_nxt;
        w_squash     = '0;
        for (int i = 0; i < STQ_DEPTH; i++) begin
            w_squash[i] = io_stq.flush &&
                (TAG_W'(STQ_IDX'(STQ_IDX'(i) - w_commit_nxt[STQ_IDX-1:0])) < w_flush_cnt);
        end
    end

    // Age-ordered forwarding scan from the youngest older store down to head
    always_comb begin
        w_scan_cnt = io_stq.ld_age - r_head;
        w_done     = 1'b0;
        w_hit      = 1'b0;
        w_stall    = 1'b0;
        w_fdata    = '0;
        for (int k = 0; k < STQ_DEPTH; k++) begin
            if (!w_done && (TAG_W'(k) < w_scan_cnt)) begin
                if (!r_rdy[STQ_IDX'(io_stq.ld_age - TAG_W'(k + 1))]) begin
                    w_stall = 1'b1;
                    w_done  = 1'b1;
                end else if (r_addr[STQ_IDX'(io_stq.ld_age - TAG_W'(k + 1))][ADDR_W-1:CMP_LO]
                             == io_stq.ld_addr[ADDR_W-1:CMP_LO]) begin
                    w_hit   = 1'b1;
                    w_fdata = r_data[STQ_IDX'(io_stq.ld_age - TAG_W'(k + 1))];
                    w_done  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head   <= '0;
            r_commit <= '0;
            r_tail   <= '0;
            r_free   <= DEPTH_TAG;
            r_valid  <= '0;
            r_rdy    <= '0;
        end else begin
            r_head   <= w_head_nxt;
            r_commit <= w_commit_nxt;
            r_tail   <= w_tail_nxt;
            r_free   <= DEPTH_TAG - (w_tail_nxt - w_head_nxt);
            if (w_exe_ok) begin
                r_rdy[STQ_IDX'(io_stq.exe_idx)] <= 1'b1;
            end
            if (w_alloc0) begin
                r_valid[STQ_IDX'(r_tail)] <= 1'b1;
                r_rdy[STQ_IDX'(r_tail)]   <= 1'b0;
            end
            if (w_alloc1) begin
                r_valid[STQ_IDX'(w_tag1)] <= 1'b1;
                r_rdy[STQ_IDX'(w_tag1)]   <= 1'b0;
            end
            if (w_drain_ack) begin
                r_valid[STQ_IDX'(r_head)] <= 1'b0;
                r_rdy[STQ_IDX'(r_head)]   <= 1'b0;
            end
            for (int i = 0; i < STQ_DEPTH; i++) begin
                if (w_squash[i]) begin
                    r_valid[i] <= 1'b0;
                    r_rdy[i]   <= 1'b0;
                end
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by r_valid/r_rdy
    always_ff @(posedge i_clk) begin
        if (w_exe_ok) begin
            r_addr[STQ_IDX'(io_stq.exe_idx)] <= io_stq.exe_addr;
            r_data[STQ_IDX'(io_stq.exe_idx)] <= io_stq.exe_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_stall <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_pr    <= '0;
        end else begin
            r_rsp_valid <= io_stq.ld_valid;
            r_rsp_hit   <= io_stq.ld_valid && w_hit;
            r_rsp_stall <= io_stq.ld_valid && w_stall;
            r_rsp_data  <= (io_stq.ld_valid && w_hit) ? w_fdata : '0;
            r_rsp_pr    <= io_stq.ld_valid ? io_stq.ld_pr : '0;
        end
    end

    // Drain FSM: head payload held stable until acked, back-to-back while committed entries remain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_dc_valid <= 1'b0;
            r_dc_addr  <= '0;
            r_dc_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_head != r_commit) begin
                        r_state    <= S_REQ;
                        r_dc_valid <= 1'b1;
                        r_dc_addr  <= r_addr[STQ_IDX'(r_head)];
                        r_dc_data  <= r_data[STQ_IDX'(r_head)];
                    end
                end
                S_REQ: begin
                    if (io_stq.dc_wr_ack) begin
                        if (w_head_nxt != w_commit_nxt) begin
                            r_dc_addr <= r_addr[STQ_IDX'(w_head_nxt)];
                            r_dc_data <= r_data[STQ_IDX'(w_head_nxt)];
                        end else begin
                            r_state    <= S_IDLE;
                            r_dc_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_dc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_stq.disp_idx0    = r_tail;
    assign io_stq.disp_idx1    = r_tail + TAG_W'(io_stq.disp_st0);
    assign io_stq.stq_free     = r_free;
    assign io_stq.ld_rsp_valid = r_rsp_valid;
    assign io_stq.ld_rsp_hit   = r_rsp_hit;
    assign io_stq.ld_rsp_stall = r_rsp_stall;
    assign io_stq.ld_rsp_data  = r_rsp_data;
    assign io_stq.ld_rsp_pr    = r_rsp_pr;
    assign io_stq.dc_wr_valid  = r_dc_valid;
    assign io_stq.dc_wr_addr   = r_dc_addr;
    assign io_stq.dc_wr_data   = r_dc_data;
endmodule
